// File: rtl/uart_arbiter.sv
// Shares one UART between N clients: round-robin TX arbitration (one byte per grant)
// and an independent RX poller that routes each received byte to the latest grantee.
module uart_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = (N > 2) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     i_tx_req,
    input  logic [8*N-1:0]   i_tx_data,
    output logic [N-1:0]     o_tx_ack,
    output logic [N-1:0]     o_rx_valid,
    output logic [7:0]       o_rx_data,
    output logic [IW-1:0]    o_rx_owner,
    output logic             o_u_we,
    output logic [31:0]      o_u_so,
    output logic             o_u_re,
    input  logic [31:0]      i_u_si,
    input  logic             i_u_wa
);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e          r_state, w_state_nxt;
    logic [IW-1:0]   r_last_grant, w_last_grant_nxt;
    logic [IW-1:0]   r_rx_owner, w_rx_owner_nxt;
    logic            r_drain_first, w_drain_first_nxt;
    logic [31:0]     r_u_so, w_u_so_nxt;
    logic            r_u_we, w_u_we_nxt;
    logic [N-1:0]    r_tx_ack, w_tx_ack_nxt;
    logic            r_u_re;
    logic [N-1:0]    r_rx_valid;
    logic [7:0]      r_rx_data;

    logic            w_found;
    logic [IW-1:0]   w_winner;
    logic [8*N-1:0]  w_data_sh;
    logic            w_rx_hit;

    // Round-robin search starting one past the last grant, wrapping modulo N.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last_grant;
        for (int off = 1; off <= int'(N); off++) begin
            int idx;
            idx = (int'(r_last_grant) + off) % int'(N);
            if (!w_found && ((i_tx_req >> idx) & N'(1)) != '0) begin
                w_found  = 1'b1;
                w_winner = IW'(idx);
            end
        end
    end

    assign w_data_sh = i_tx_data >> {w_winner, 3'b000};

    always_comb begin
        w_state_nxt       = r_state;
        w_last_grant_nxt  = r_last_grant;
        w_rx_owner_nxt    = r_rx_owner;
        w_drain_first_nxt = 1'b0;
        w_u_so_nxt        = r_u_so;
        w_u_we_nxt        = 1'b0;
        w_tx_ack_nxt      = '0;
        unique case (r_state)
            StIdle: begin
                if (!i_u_wa && w_found) begin
                    w_last_grant_nxt = w_winner;
                    w_rx_owner_nxt   = w_winner;
                    w_u_so_nxt       = {24'b0, w_data_sh[7:0]};
                    w_state_nxt      = StIssue;
                end
            end
            StIssue: begin
                w_u_we_nxt        = 1'b1;
                w_tx_ack_nxt      = N'(1) << r_last_grant;
                w_drain_first_nxt = 1'b1;
                w_state_nxt       = StDrain;
            end
            StDrain: begin
                // First DRAIN cycle is the u_we cycle itself; u_wa is only meaningful after.
                if (!r_drain_first && !i_u_wa) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_last_grant  <= IW'(N - 1);
            r_rx_owner    <= '0;
            r_drain_first <= 1'b0;
            r_u_so        <= '0;
            r_u_we        <= 1'b0;
            r_tx_ack      <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_last_grant  <= w_last_grant_nxt;
            r_rx_owner    <= w_rx_owner_nxt;
            r_drain_first <= w_drain_first_nxt;
            r_u_so        <= w_u_so_nxt;
            r_u_we        <= w_u_we_nxt;
            r_tx_ack      <= w_tx_ack_nxt;
        end
    end

    // The !r_u_re term blocks a second pop while the UART is still clearing its flag.
    assign w_rx_hit = (i_u_si != 32'hFFFF_FFFF) && !r_u_re;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_u_re     <= 1'b0;
            r_rx_valid <= '0;
            r_rx_data  <= '0;
        end else begin
            r_u_re     <= w_rx_hit;
            r_rx_valid <= w_rx_hit ? (N'(1) << r_rx_owner) : '0;
            if (w_rx_hit) begin
                r_rx_data <= i_u_si[7:0];
            end
        end
    end

    assign o_tx_ack   = r_tx_ack;
    assign o_rx_valid = r_rx_valid;
    assign o_rx_data  = r_rx_data;
    assign o_rx_owner = r_rx_owner;
    assign o_u_we     = r_u_we;
    assign o_u_so     = r_u_so;
    assign o_u_re     = r_u_re;

endmodule

// File: tb/tb_uart_arbiter.sv
// Scoreboard bench for uart_arbiter: expected TX/RX beats are queued as stimulus is
// driven and compared when the DUT strobes; a small UART busy model drives u_wa.
module tb_uart_arbiter;
    localparam int N  = 2;
    localparam int IW = 1;

    typedef struct packed {
        logic [N-1:0] oh;
        logic [7:0]   b;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    tx_req;
    logic [8*N-1:0]  tx_data;
    logic [N-1:0]    tx_ack;
    logic [N-1:0]    rx_valid;
    logic [7:0]      rx_data;
    logic [IW-1:0]   rx_owner;
    logic            u_we;
    logic [31:0]     u_so;
    logic            u_re;
    logic [31:0]     u_si;
    logic            u_wa;

    int   checks = 0;
    int   failures = 0;
    int   busy_cnt = 0;
    int   re_count = 0;
    int   ack0_count = 0;
    exp_t txq[$];
    exp_t rxq[$];

    always #5 clk = ~clk;

    uart_arbiter #(.N(N), .IW(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_tx_req   (tx_req),
        .i_tx_data  (tx_data),
        .o_tx_ack   (tx_ack),
        .o_rx_valid (rx_valid),
        .o_rx_data  (rx_data),
        .o_rx_owner (rx_owner),
        .o_u_we     (u_we),
        .o_u_so     (u_so),
        .o_u_re     (u_re),
        .i_u_si     (u_si),
        .i_u_wa     (u_wa)
    );

    // UART busy model: busy during u_we and for 4 cycles of frame shifting afterwards.
    always @(posedge clk) begin
        if (u_we === 1'b1) busy_cnt <= 4;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign u_wa = (u_we === 1'b1) || (busy_cnt != 0);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (u_we === 1'b1 || (|tx_ack) === 1'b1) begin
            if (txq.size() == 0) begin
                check_eq("tx_unexpected", {31'b0, u_we}, 32'h0);
            end else begin
                exp_t e;
                e = txq.pop_front();
                check_eq("tx_we", {31'b0, u_we}, 32'h1);
                check_eq("tx_so", u_so, {24'h0, e.b});
                check_eq("tx_ack", {30'b0, tx_ack}, {30'b0, e.oh});
                check_eq("tx_we_while_busy", busy_cnt, 0);
            end
            if (tx_ack[0] === 1'b1) ack0_count++;
        end
        if (u_re === 1'b1) re_count++;
        if ((|rx_valid) === 1'b1) begin
            if (rxq.size() == 0) begin
                check_eq("rx_unexpected", {30'b0, rx_valid}, 32'h0);
            end else begin
                exp_t e;
                e = rxq.pop_front();
                check_eq("rx_valid", {30'b0, rx_valid}, {30'b0, e.oh});
                check_eq("rx_data", {24'b0, rx_data}, {24'h0, e.b});
            end
        end
    end

    task automatic wait_ack(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (|tx_ack) begin
                seen = 1;
                break;
            end
        end
        check_eq({tag, "_ack_seen"}, {31'b0, seen}, 32'h1);
    endtask

    task automatic rx_byte(input logic [31:0] word, input logic [N-1:0] oh, input string tag);
        bit seen;
        int re0;
        seen = 0;
        re0  = re_count;
        rxq.push_back('{oh: oh, b: word[7:0]});
        u_si = word;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (u_re) begin
                seen = 1;
                break;
            end
        end
        u_si = 32'hFFFF_FFFF;
        check_eq({tag, "_re_seen"}, {31'b0, seen}, 32'h1);
        step(4);
        check_eq({tag, "_re_pulses"}, re_count - re0, 1);
    endtask

    initial begin
        int n;
        rst_n   = 1'b0;
        tx_req  = '0;
        tx_data = '0;
        u_si    = 32'hFFFF_FFFF;
        step(3);
        check_eq("reset_outputs",
                 {u_we, u_re, tx_ack, rx_valid, rx_data, rx_owner, 17'b0} | u_so, 32'h0);
        rst_n = 1'b1;
        step(1);

        // Single send from client 1: u_we/ack visible two cycles after the request.
        tx_data = 16'h4100;
        tx_req  = 2'b10;
        txq.push_back('{oh: 2'b10, b: 8'h41});
        step(2);
        check_eq("single_we_latency", {31'b0, u_we}, 32'h1);
        check_eq("single_owner", {31'b0, rx_owner}, 32'h1);
        tx_req = '0;
        step(8);

        rx_byte(32'h0000_005A, 2'b10, "rx_owner1");

        // Contention: both clients request continuously; grants alternate 0,1,0,1.
        tx_data = 16'h55AA;
        tx_req  = 2'b11;
        for (int k = 0; k < 2; k++) begin
            txq.push_back('{oh: 2'b01, b: 8'hAA});
            txq.push_back('{oh: 2'b10, b: 8'h55});
        end
        n = 0;
        for (int i = 0; i < 300 && n < 4; i++) begin
            step(1);
            if (u_we) n++;
        end
        tx_req = '0;
        check_eq("contention_grants", n, 4);
        step(8);

        // RX detect and TX grant to client 0 in the same cycle; owner was 1.
        tx_data = 16'h00C3;
        tx_req  = 2'b01;
        u_si    = 32'h0000_0033;
        rxq.push_back('{oh: 2'b10, b: 8'h33});
        txq.push_back('{oh: 2'b01, b: 8'hC3});
        step(1);
        check_eq("sim_re", {31'b0, u_re}, 32'h1);
        check_eq("sim_owner_updated", {31'b0, rx_owner}, 32'h0);
        u_si = 32'hFFFF_FFFF;
        step(1);
        check_eq("sim_ack", {30'b0, tx_ack}, 32'h1);
        tx_req = '0;
        step(8);
        rx_byte(32'h1234_5677, 2'b01, "rx_owner0");

        // Withdraw: client 0 pulses its request during DRAIN; client 1 holds.
        tx_data = 16'h1100;
        tx_req  = 2'b10;
        txq.push_back('{oh: 2'b10, b: 8'h11});
        wait_ack("wd_first");
        tx_data = 16'h6600;
        tx_req  = 2'b11;
        n = ack0_count;
        step(1);
        tx_req = 2'b10;
        txq.push_back('{oh: 2'b10, b: 8'h66});
        wait_ack("wd_second");
        tx_req = '0;
        step(8);
        check_eq("wd_no_ack0", ack0_count - n, 0);

        // Reset mid-DRAIN after a client 0 grant; client 0 must still win first afterwards.
        tx_data = 16'h0022;
        tx_req  = 2'b01;
        txq.push_back('{oh: 2'b01, b: 8'h22});
        wait_ack("rst_pre");
        rst_n   = 1'b0;
        tx_data = 16'h8899;
        tx_req  = 2'b11;
        step(1);
        check_eq("rst_mid_drain",
                 {u_we, u_re, tx_ack, rx_valid, rx_data, rx_owner, 17'b0} | u_so, 32'h0);
        rst_n = 1'b1;
        txq.push_back('{oh: 2'b01, b: 8'h99});
        wait_ack("rst_post");
        tx_req = '0;
        step(10);

        check_eq("txq_drained", txq.size(), 0);
        check_eq("rxq_drained", rxq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_arbiter.md
Name: uart_arbiter

Overview:
- Shares one uart instance between N client ports.
- TX side: round-robin arbitration, one byte per grant; holds off further grants until the UART reports idle.
- RX side: polls the UART receive word, pops each byte with a one-cycle read strobe, and delivers it to the RX owner (the client granted most recently).
- Sits between the SoC bus clients (CPU, debug monitor) and the uart block.

Parameters:
- N, 2, number of clients (2..8).
- IW, $clog2(N) (minimum 1), client index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- tx_req  in  N  per-client byte-send request; held until tx_ack
- tx_data  in  8*N  per-client byte; client i uses bits [8i+7:8i]
- tx_ack  out  N  one-cycle pulse: byte accepted and issued to the UART
- rx_valid  out  N  one-cycle pulse to the RX owner: rx_data valid
- rx_data  out  8  received byte, shared by all clients
- rx_owner  out  IW  current RX owner index
- u_we  out  1  UART write strobe
- u_so  out  32  UART write data
- u_re  out  1  UART read strobe (pop)
- u_si  in  32  UART receive word; 0xFFFFFFFF = empty, else {24'b0, byte}
- u_wa  in  1  UART busy (combinationally high during u_we and while a frame shifts)

Behaviour:
- Reset: rst_n is synchronous, active-low, on clk. All outputs registered.
  - tx_ack=0, rx_valid=0, rx_data=0, rx_owner=0, u_we=0, u_so=0, u_re=0.
  - State=IDLE; last_grant=N-1, so client 0 has first priority.
- TX FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - Waits while u_wa=1 (covers UART still busy after reset).
  - When u_wa=0 and tx_req is nonzero, selects the winner W by round-robin: search starts at last_grant+1 and wraps modulo N.
  - Latches u_so={24'b0, tx_data[W]}. Bits 31:8 are zero so the UART forms a 0 start bit.
  - last_grant<=W, rx_owner<=W, go ISSUE.
- ISSUE (exactly 1 cycle): u_we=1, tx_ack[W]=1; go DRAIN.
  - Grant to u_we is one cycle. Request to ack is 2 cycles minimum.
- DRAIN:
  - The cycle after ISSUE is unconditional (UART counter is loaded, u_wa=1).
  - Afterwards: stay while u_wa=1; return to IDLE on the first cycle u_wa=0.
  - Back-to-back bytes are therefore separated by at least 1 idle cycle.
- Request rules:
  - A client may drop tx_req before its ack (withdraw). Arbitration samples only in IDLE.
  - A request dropped during ISSUE still gets its byte sent and acked.
  - tx_data must stay stable until ack. Only the IDLE-cycle sample is used.
- Round-robin is fair: with all N requesting continuously, each client is granted exactly once per N grants.
- RX path runs independently of the TX FSM:
  - When u_si!=0xFFFFFFFF and u_re=0, the next cycle drives:
    - u_re=1 for exactly one cycle;
    - rx_data<=u_si[7:0];
    - rx_valid[rx_owner]=1, using the rx_owner value at the detect cycle.
  - The u_re=0 qualifier stops a double pop in the cycle the UART clears its valid flag.
  - Sustained polling rate: at most one byte per 2 cycles. The UART delivers far slower, so no loss.
- Simultaneous RX detect and TX grant in the same cycle: the byte goes to the old owner, and the owner updates on the following edge.
- u_si equal to 0xFFFFFFFF is always treated as empty. Non-empty words with nonzero upper bits are taken as valid; upper bits are ignored.
- Reset mid-DRAIN or mid-ISSUE: next cycle is IDLE with all strobes 0. No tx_ack is issued for an aborted request.
- No combinational paths from inputs to outputs.

Test Plan:
- Single send: client 1 tx_req=1, tx_data=0x41, u_wa model idle → u_we pulse with u_so=0x00000041 at cycle 2 after request; tx_ack=2'b10 in the same cycle; rx_owner=1.
- Contention (N=2): both request continuously with 0xAA and 0x55 → grants alternate 0,1,0,1; u_so sequence 0xAA,0x55,0xAA,0x55; no u_we issued while u_wa=1.
- RX routing: after a grant to client 1, drive u_si=0x0000005A until u_re → exactly one u_re pulse; rx_valid=2'b10, rx_data=0x5A; u_si then 0xFFFFFFFF → no further pulses.
- Simultaneous: RX byte 0x33 arrives in the same cycle client 0 is granted (previous owner 1) → rx_valid[1] pulses with 0x33; the next RX byte goes to client 0.
- Withdraw: client 0 raises then drops tx_req while the FSM is in DRAIN, client 1 holds its request → next grant goes to client 1; client 0 gets no tx_ack.
- Reset mid-DRAIN: assert rst_n=0 for 1 cycle → all outputs 0, state IDLE; after release, a pending client 0 request is granted first.
